// File: rtl/present_key_schedule.sv
// PRESENT-80 key schedule: loads an 80-bit key on start and streams round keys
// K1..K(NUM_ROUND_KEYS) over a valid/ready handshake, one per accepted beat.
module present_key_schedule #(
    parameter int NUM_ROUND_KEYS = 32
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [79:0] key_in,
    input  logic        start,
    output logic        busy,
    output logic        rk_valid,
    input  logic        rk_ready,
    output logic [63:0] round_key,
    output logic [5:0]  round_idx,
    output logic        rk_last,
    output logic        done
);

    typedef enum logic {IDLE, EMIT} state_t;

    localparam logic [5:0] LAST_IDX = 6'(NUM_ROUND_KEYS);

    state_t      state;
    logic [79:0] key_reg;
    logic [5:0]  idx_reg;
    logic        accept;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hC;  4'h1: y = 4'h5;  4'h2: y = 4'h6;  4'h3: y = 4'hB;
            4'h4: y = 4'h9;  4'h5: y = 4'h0;  4'h6: y = 4'hA;  4'h7: y = 4'hD;
            4'h8: y = 4'h3;  4'h9: y = 4'hE;  4'hA: y = 4'hF;  4'hB: y = 4'h8;
            4'hC: y = 4'h4;  4'hD: y = 4'h7;  4'hE: y = 4'h1;  default: y = 4'h2;
        endcase
        return y;
    endfunction

    // Rotate left 61, S-box the top nibble, then fold the round counter into bits 19:15.
    function automatic logic [79:0] update(input logic [79:0] k, input logic [5:0] c);
        logic [79:0] t;
        t          = {k[18:0], k[79:19]};
        t[79:76]   = sbox(t[79:76]);
        t[19:15]   = t[19:15] ^ c[4:0];
        return t;
    endfunction

    assign accept    = rk_valid & rk_ready;
    assign round_key = key_reg[79:16];
    assign round_idx = idx_reg;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state    <= IDLE;
            key_reg  <= '0;
            idx_reg  <= '0;
            rk_valid <= 1'b0;
            busy     <= 1'b0;
            rk_last  <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        key_reg  <= key_in;
                        idx_reg  <= 6'd1;
                        state    <= EMIT;
                        rk_valid <= 1'b1;
                        busy     <= 1'b1;
                        rk_last  <= (LAST_IDX == 6'd1);
                    end
                end
                EMIT: begin
                    if (accept) begin
                        if (idx_reg == LAST_IDX) begin
                            // key_reg/idx_reg intentionally keep the final values
                            state    <= IDLE;
                            rk_valid <= 1'b0;
                            busy     <= 1'b0;
                            rk_last  <= 1'b0;
                            done     <= 1'b1;
                        end else begin
                            key_reg <= update(key_reg, idx_reg);
                            idx_reg <= idx_reg + 6'd1;
                            rk_last <= (idx_reg + 6'd1 == LAST_IDX);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/present_key_schedule.md
Name: present_key_schedule

Overview:
- PRESENT-80 key schedule engine, directly upstream of the encrypt datapath.
- Loads an 80-bit user key on a start pulse.
- Streams round keys K1..K32 (64 bits each) one at a time over a valid/ready handshake, each tagged with its round index.
- Encrypt consumes one round key per accepted beat; backpressure stalls the schedule without losing state.

Parameters:
- NUM_ROUND_KEYS, 32, number of round keys emitted per key load. Legal range 1..32; values outside this range are illegal.

Ports:
- clock  input  1  rising-edge clock.
- reset_n  input  1  synchronous, active-low reset.
- key_in  input  80  user key; sampled only on an accepted start.
- start  input  1  load request; accepted only in IDLE.
- busy  output  1  high from the cycle after an accepted start until the final key is accepted.
- rk_valid  output  1  round_key/round_idx/rk_last are valid.
- rk_ready  input  1  consumer accepts the current round key.
- round_key  output  64  current round key Ki = key_reg[79:16].
- round_idx  output  6  index i of the current key, 1..NUM_ROUND_KEYS.
- rk_last  output  1  high with rk_valid when round_idx == NUM_ROUND_KEYS.
- done  output  1  one-cycle pulse the cycle after the final key is accepted.

Behaviour:
- Reset (reset_n low at a clock edge):
  - State goes to IDLE; key_reg = 0, round_idx = 0.
  - rk_valid = 0, busy = 0, rk_last = 0, done = 0, round_key = 0.
  - Reset overrides everything, including mid-stream; there is no partial output afterwards.
- States:
  - IDLE: rk_valid = 0, busy = 0. On start = 1: key_reg <= key_in, round_idx <= 1, go to EMIT. In the next cycle rk_valid = 1 and round_key = key_in[79:16] (latency 1 cycle).
  - EMIT: rk_valid = 1, busy = 1. Outputs hold stable while rk_ready = 0, for any number of cycles.
  - On accept (rk_valid & rk_ready) with round_idx < NUM_ROUND_KEYS:
    - key_reg <= update(key_reg, round_idx).
    - round_idx <= round_idx + 1.
    - The next key is presented the following cycle, so back-to-back accepts give one key per cycle.
  - On accept with round_idx == NUM_ROUND_KEYS: go to IDLE; rk_valid drops next cycle; done = 1 for exactly that cycle; key_reg and round_idx keep their last values.
- update(k, c), evaluated in this order:
  1. Rotate left by 61: t = {k[18:0], k[79:19]}.
  2. t[79:76] <= S(t[79:76]), where S is the PRESENT S-box C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2 for input 0..F.
  3. t[19:15] <= t[19:15] XOR c[4:0].
- The counter XOR uses c = index of the key just emitted (1..31).
- start while busy is ignored: key_in is not sampled and the stream is unaffected.
- start in the same cycle as done: accepted, and a new stream begins. done and the new load coincide; rk_valid is low for that one cycle only.
- NUM_ROUND_KEYS = 1: a single beat with rk_last = 1.
- round_key is registered directly from key_reg; there is no combinational path from rk_ready to any output.

Test Plan:
- Reset, then key_in = 0, start pulse, rk_ready held 1 -> K1 = 0000000000000000 (idx 1), K2 = C000000000000000, K3 = 5000180000000001. Keys arrive on consecutive cycles; rk_last and then done follow at idx 32.
- Same zero key, full stream -> K32 = 6DAB31744F41D700 with rk_last = 1; done pulses exactly once, one cycle after the K32 accept.
- Backpressure: rk_ready = 0 for 5 cycles during K2 -> round_key stays C000000000000000 and idx stays 2; after release, K3 = 5000180000000001 follows with no skip or duplicate.
- start pulsed with key_in = FFFF_FFFF_FFFF_FFFF_FFFF while streaming at idx 10 -> stream continues unchanged; the new key is not loaded.
- reset_n low at idx 7 -> next cycle rk_valid = 0, busy = 0, round_idx = 0. A subsequent start with key_in = 0 restarts at K1 = 0000000000000000.
- start asserted in the done cycle with key_in = 0 -> new K1 appears the following cycle with idx 1; no gap beyond one cycle.
